// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch front end.
package fetch_pkg;

    // Widest address the immediate helper supports.
    localparam int unsigned MAX_ADDR_W = 64;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        RD_COND   = 2'b00,
        RD_UNCOND = 2'b01,
        RD_REG    = 2'b10,
        RD_RSVD   = 2'b11
    } redirect_mode_t;

    // Sign-extend the low 'width' bits of imm and scale the word offset to bytes.
    function automatic logic [MAX_ADDR_W-1:0] sext_shift(input logic [MAX_ADDR_W-1:0] imm,
                                                         input int unsigned           width);
        logic [MAX_ADDR_W-1:0] mask;
        logic                  sign;
        mask = (MAX_ADDR_W'(1) << width) - MAX_ADDR_W'(1);
        if (width >= MAX_ADDR_W) begin
            mask = '1;
        end
        sign = imm[6'(width - 32'd1)];
        return ((imm & mask) | (~mask & {MAX_ADDR_W{sign}})) << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO holding fetched {instruction, pc} pairs; flush empties it.
module fetch_queue #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && !flush && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_push && !do_pop) count_d = count_q + CntW'(1);
            if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC register, branch target logic, one-deep imem pipeline and fetch queue.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 64,
    parameter int unsigned       INST_W       = 32,
    parameter int unsigned       IMM_COND_W   = 19,
    parameter int unsigned       IMM_UNCOND_W = 26,
    parameter int unsigned       FQ_DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [1:0]              redirect_mode,
    input  logic [ADDR_W-1:0]       redirect_pc,
    input  logic [IMM_COND_W-1:0]   imm_cond,
    input  logic [IMM_UNCOND_W-1:0] imm_uncond,
    input  logic [ADDR_W-1:0]       redirect_reg,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INST_W-1:0]       imem_rdata,
    output logic                    dec_valid,
    output logic [INST_W-1:0]       dec_inst,
    output logic [ADDR_W-1:0]       dec_pc,
    input  logic                    dec_ready,
    output logic                    redirect_misaligned
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned QW   = INST_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              misaligned_q, misaligned_d;
    logic [ADDR_W-1:0] target;
    logic [CntW:0]     occupancy;
    logic              issue, push, pop;
    logic [QW-1:0]     q_rdata;
    logic [CntW-1:0]   q_count;
    logic              q_empty, q_full;

    // Branch target selection; reserved mode behaves as register mode.
    always_comb begin
        target = {redirect_reg[ADDR_W-1:2], 2'b00};
        unique case (redirect_mode_t'(redirect_mode))
            RD_COND:   target = redirect_pc
                              + ADDR_W'(sext_shift(MAX_ADDR_W'(imm_cond), IMM_COND_W));
            RD_UNCOND: target = redirect_pc
                              + ADDR_W'(sext_shift(MAX_ADDR_W'(imm_uncond), IMM_UNCOND_W));
            RD_REG, RD_RSVD: target = {redirect_reg[ADDR_W-1:2], 2'b00};
        endcase
    end

    // Entries already queued plus the one in flight must leave room for a new response.
    assign occupancy = {1'b0, q_count} + (CntW + 1)'(inflight_q);
    assign issue     = !reset && !redirect_valid && (occupancy < (CntW + 1)'(FQ_DEPTH));
    assign push      = inflight_q && !redirect_valid;
    assign pop       = dec_valid && dec_ready;

    assign imem_req            = issue;
    assign imem_addr           = fetch_pc_q;
    assign dec_valid           = !q_empty && !redirect_valid;
    assign dec_inst            = q_rdata[QW-1 -: INST_W];
    assign dec_pc              = q_rdata[ADDR_W-1:0];
    assign redirect_misaligned = misaligned_q;

    // PC advance / redirect and in-flight tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        misaligned_d  = redirect_valid && redirect_mode[1] && (|redirect_reg[1:0]);
        if (redirect_valid) begin
            fetch_pc_d = target;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(INST_BYTES);
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // The issue rule must never let a response land in a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && q_full)) else $error("fetch queue overflow");
        end
    end

    fetch_queue #(
        .WIDTH(QW),
        .DEPTH(FQ_DEPTH)
    ) u_fetch_queue (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata({imem_rdata, inflight_pc_q}),
        .pop  (pop),
        .flush(redirect_valid),
        .rdata(q_rdata),
        .count(q_count),
        .empty(q_empty),
        .full (q_full)
    );

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined LEGv8 core. It owns the PC register, computes conditional, unconditional and register branch targets, and issues one request per cycle to an external synchronous instruction memory. Returned instructions are buffered with their PCs in a small fetch queue, which feeds decode through a valid/ready handshake. A redirect from execute flushes the queue and squashes any in-flight fetch.

Parameters:
ADDR_W, 64, PC/address width in bits
INST_W, 32, instruction width in bits
IMM_COND_W, 19, conditional-branch immediate width (word offset)
IMM_UNCOND_W, 26, unconditional-branch immediate width (word offset)
FQ_DEPTH, 4, fetch queue entries; legal range 2..16
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  execute requests a PC redirect this cycle
redirect_mode  in  2  target mode: 00 cond (imm_cond), 01 uncond (imm_uncond), 10 register, 11 reserved (treated as 10)
redirect_pc  in  ADDR_W  PC of the branch instruction
imm_cond  in  IMM_COND_W  signed word offset for conditional branch
imm_uncond  in  IMM_UNCOND_W  signed word offset for unconditional branch
redirect_reg  in  ADDR_W  register target (BR)
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  memory read byte address
imem_rdata  in  INST_W  read data, valid exactly 1 cycle after imem_req
dec_valid  out  1  queue head is valid
dec_inst  out  INST_W  head instruction
dec_pc  out  ADDR_W  head PC
dec_ready  in  1  decode accepts the head
redirect_misaligned  out  1  registered one-cycle pulse: register target had nonzero bits [1:0]

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC; queue empty (count=0, pointers 0); inflight=0; imem_req=0; dec_valid=0; redirect_misaligned=0. Reset asserted mid-operation discards all state immediately. First request issues in the first cycle after reset deasserts.
- Target computation (combinational):
  - cond: redirect_pc + (sext(imm_cond)<<2).
  - uncond: redirect_pc + (sext(imm_uncond)<<2).
  - register: {redirect_reg[ADDR_W-1:2],2'b00}.
  - All adds are modulo 2^ADDR_W.
- Issue rule: imem_req = !redirect_valid && (count + inflight < FQ_DEPTH).
  - Uses count before any same-cycle pop.
  - On issue: imem_addr=fetch_pc; fetch_pc <= fetch_pc+4, wrapping modulo 2^ADDR_W; inflight <= 1; inflight_pc <= fetch_pc.
  - When not issuing: imem_addr holds fetch_pc; inflight <= 0.
- Response: if inflight=1 and no redirect this cycle, push {imem_rdata, inflight_pc} into the queue at the clock edge.
- Pop: when dec_valid && dec_ready. Push and pop in the same cycle are both allowed; count is unchanged.
- Throughput: sustained 1 instruction/cycle when dec_ready stays high. Fetch-to-decode latency is 2 cycles (request cycle, then push; visible at dec_valid the following cycle).
- Full: the issue rule guarantees a push never targets a full queue. Overflow is an assertion failure.
- Empty: dec_valid=0; dec_inst and dec_pc are don't-care.
- Redirect (highest priority):
  - dec_valid is forced to 0 in the redirect cycle, so no pop occurs.
  - The queue is flushed (count=0).
  - The in-flight response is discarded.
  - fetch_pc <= target; no request issues this cycle.
  - The next cycle issues to target.
  - redirect_misaligned <= (mode is register or reserved) && |redirect_reg[1:0].
- Back-to-back redirects: each one is applied; the last one wins.
- Queue implementation: circular buffer with log2 pointers; pointers wrap at FQ_DEPTH, including depths that are not powers of two.

Decomposition:
- Package fetch_pkg:
  - redirect_mode_t enum (RD_COND, RD_UNCOND, RD_REG, RD_RSVD).
  - INST_BYTES=4 and WORD_SHIFT=2.
  - Function sext_shift for immediate extension and scaling.
- Sub-module fetch_queue: parametrised synchronous FIFO (WIDTH=INST_W+ADDR_W, DEPTH) with push, pop, flush, count, empty and full.
- pc_fetch_unit holds the PC, target logic, issue/inflight control and the queue instance.

Test Plan:
- Reset then stream, dec_ready=1, imem returns addr-derived data -> dec_pc sequence 0,4,8,12...; first dec_valid 2 cycles after the first request; one instruction per cycle.
- Hold dec_ready=0 with FQ_DEPTH=4 -> exactly 4 entries fill and imem_req drops. Raise dec_ready -> PCs 0,4,8,12 in order, no loss or duplicates, then issue resumes at 16.
- Conditional redirect at redirect_pc=0x40, imm_cond=-4 (19'h7FFFC) -> next imem_addr=0x30. The in-flight response is not queued, and dec_valid=0 in the redirect cycle.
- Uncond redirect at redirect_pc=0x100, imm_uncond=26'h0000010 -> target 0x140. A redirect in the following cycle (register mode, 0x200) overrides it -> next request at 0x200.
- Register redirect with redirect_reg=0x1003 -> imem_addr=0x1000 and redirect_misaligned pulses exactly one cycle.
- Assert reset mid-stream with a full queue and an inflight fetch -> dec_valid and imem_req drop asynchronously. After release, the first request is at RESET_PC.
- fetch_pc=2^ADDR_W-4 -> next request at 0 (wrap).
